// File: rtl/viterbi_pkg.sv
// Shared trellis helpers for the Viterbi ACS datapath: state count, predecessor
// and input-bit mapping, branch-metric indexing and the normalisation threshold.
package viterbi_pkg;

  function automatic int unsigned num_states(input int unsigned k);
    return 32'd1 << (k - 32'd1);
  endfunction

  function automatic int unsigned pred0(input int unsigned s, input int unsigned k);
    return (s << 1) & (num_states(k) - 32'd1);
  endfunction

  function automatic int unsigned pred1(input int unsigned s, input int unsigned k);
    return pred0(s, k) + 32'd1;
  endfunction

  function automatic int unsigned in_bit(input int unsigned s, input int unsigned k);
    return s >> (k - 32'd2);
  endfunction

  function automatic int unsigned bm_index(input int unsigned p, input int unsigned b);
    return 32'd2 * p + b;
  endfunction

  function automatic int unsigned norm_th(input int unsigned w);
    return 32'd1 << (w - 32'd1);
  endfunction

endpackage

// File: rtl/acs_cell.sv
// Single-state add-compare-select: two saturating candidate sums, pick the
// smaller one, ties go to the candidate from the even predecessor.
module acs_cell
  import viterbi_pkg::*;
#(
  parameter int W  = 8,
  parameter int BW = 2
) (
  input  logic [W-1:0]  pm0,
  input  logic [W-1:0]  pm1,
  input  logic [BW-1:0] bm0,
  input  logic [BW-1:0] bm1,
  output logic [W-1:0]  pm_new,
  output logic          dec
);

  logic [W:0]   sum0;
  logic [W:0]   sum1;
  logic [W-1:0] sat0;
  logic [W-1:0] sat1;

  assign sum0 = {1'b0, pm0} + {{(W+1-BW){1'b0}}, bm0};
  assign sum1 = {1'b0, pm1} + {{(W+1-BW){1'b0}}, bm1};

  // The carry bit flags overflow; clamp to all-ones instead of wrapping.
  assign sat0 = sum0[W] ? {W{1'b1}} : sum0[W-1:0];
  assign sat1 = sum1[W] ? {W{1'b1}} : sum1[W-1:0];

  assign dec    = (sat1 < sat0);
  assign pm_new = dec ? sat1 : sat0;

endmodule

// File: rtl/acs_array.sv
// Parametrised ACS engine holding the path metrics as feedback registers.
// Define ACS_BEST_STATE_EN to add best_state/best_metric argmin outputs.
module acs_array
  import viterbi_pkg::*;
#(
  parameter  int K       = 3,
  parameter  int W       = 8,
  parameter  int BW      = 2,
  parameter  int INIT_PM = 2 ** (W - 2),
  localparam int NS      = 2 ** (K - 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bm_valid,
  input  logic [NS*2*BW-1:0] bm,
  output logic             dec_valid,
  output logic [NS-1:0]    dec,
  output logic [NS*W-1:0]  pm_out,
`ifdef ACS_BEST_STATE_EN
  output logic [K-2:0]     best_state,
  output logic [W-1:0]     best_metric,
`endif
  output logic             norm_evt
);

  localparam logic [W-1:0] INIT_W  = W'(INIT_PM);
  localparam logic [W-1:0] NORM_TH = W'(norm_th(W));

  logic [W-1:0]  pm_reg [NS];
  logic [W-1:0]  cand_pm [NS];
  logic [W-1:0]  pm_next [NS];
  logic [NS-1:0] cand_dec;
  logic [NS-1:0] dec_reg;
  logic          dec_valid_reg;
  logic          norm_evt_reg;
  logic [W-1:0]  min_val;
  logic          norm_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NS; gi++) begin : g_state
      localparam int P0  = int'(pred0(gi, K));
      localparam int P1  = int'(pred1(gi, K));
      localparam int B   = int'(in_bit(gi, K));
      localparam int IX0 = int'(bm_index(P0, B)) * BW;
      localparam int IX1 = int'(bm_index(P1, B)) * BW;

      acs_cell #(.W(W), .BW(BW)) u_cell (
        .pm0    (pm_reg[P0]),
        .pm1    (pm_reg[P1]),
        .bm0    (bm[IX0 +: BW]),
        .bm1    (bm[IX1 +: BW]),
        .pm_new (cand_pm[gi]),
        .dec    (cand_dec[gi])
      );

      assign pm_next[gi]          = norm_hit ? (cand_pm[gi] - NORM_TH) : cand_pm[gi];
      assign pm_out[gi*W +: W]    = pm_reg[gi];
    end
  endgenerate

`ifdef ACS_BEST_STATE_EN
  logic [K-2:0] min_idx;
`endif

  // Strict less-than keeps the lowest index on ties.
  always_comb begin
    min_val = cand_pm[0];
`ifdef ACS_BEST_STATE_EN
    min_idx = '0;
`endif
    for (int i = 1; i < NS; i++) begin
      if (cand_pm[i] < min_val) begin
        min_val = cand_pm[i];
`ifdef ACS_BEST_STATE_EN
        min_idx = (K-1)'(i);
`endif
      end
    end
  end

  assign norm_hit = (min_val >= NORM_TH);

  always_ff @(posedge clk) begin
    if (rst || start) begin
      for (int i = 0; i < NS; i++) begin
        pm_reg[i] <= (i == 0) ? '0 : INIT_W;
      end
      dec_reg       <= '0;
      dec_valid_reg <= 1'b0;
      norm_evt_reg  <= 1'b0;
    end else if (bm_valid) begin
      for (int i = 0; i < NS; i++) begin
        pm_reg[i] <= pm_next[i];
      end
      dec_reg       <= cand_dec;
      dec_valid_reg <= 1'b1;
      norm_evt_reg  <= norm_hit;
    end else begin
      dec_valid_reg <= 1'b0;
      norm_evt_reg  <= 1'b0;
    end
  end

`ifdef ACS_BEST_STATE_EN
  logic [K-2:0] best_state_reg;
  logic [W-1:0] best_metric_reg;

  always_ff @(posedge clk) begin
    if (rst || start) begin
      best_state_reg  <= '0;
      best_metric_reg <= '0;
    end else if (bm_valid) begin
      best_state_reg  <= min_idx;
      best_metric_reg <= norm_hit ? (min_val - NORM_TH) : min_val;
    end
  end

  assign best_state  = best_state_reg;
  assign best_metric = best_metric_reg;
`endif

  assign dec       = dec_reg;
  assign dec_valid = dec_valid_reg;
  assign norm_evt  = norm_evt_reg;

endmodule

// File: tb/tb_acs_array.sv
// Directed self-checking bench for acs_array (K=3, W=8, BW=2, INIT_PM=64);
// acs_cell is also driven directly to reach saturation corners.
module tb_acs_array;

  logic        clk;
  logic        rst;
  logic        start;
  logic        bm_valid;
  logic [15:0] bm;
  logic        dec_valid;
  logic [3:0]  dec;
  logic [31:0] pm_out;
  logic        norm_evt;
`ifdef ACS_BEST_STATE_EN
  logic [1:0]  best_state;
  logic [7:0]  best_metric;
`endif

  int checks = 0;
  int errors = 0;

  acs_array #(.K(3), .W(8), .BW(2), .INIT_PM(64)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .bm_valid    (bm_valid),
    .bm          (bm),
    .dec_valid   (dec_valid),
    .dec         (dec),
    .pm_out      (pm_out),
`ifdef ACS_BEST_STATE_EN
    .best_state  (best_state),
    .best_metric (best_metric),
`endif
    .norm_evt    (norm_evt)
  );

  logic [7:0] c_pm0, c_pm1, c_pm_new;
  logic [1:0] c_bm0, c_bm1;
  logic       c_dec;

  acs_cell #(.W(8), .BW(2)) u_cell_chk (
    .pm0    (c_pm0),
    .pm1    (c_pm1),
    .bm0    (c_bm0),
    .bm1    (c_bm1),
    .pm_new (c_pm_new),
    .dec    (c_dec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  function automatic logic [31:0] pmv(input int s3, input int s2, input int s1, input int s0);
    pmv = {s3[7:0], s2[7:0], s1[7:0], s0[7:0]};
  endfunction

  // Argument i is bm(p,b) with i = 2p+b.
  function automatic logic [15:0] mkbm(input int v0, input int v1, input int v2, input int v3,
                                       input int v4, input int v5, input int v6, input int v7);
    mkbm = {v7[1:0], v6[1:0], v5[1:0], v4[1:0], v3[1:0], v2[1:0], v1[1:0], v0[1:0]};
  endfunction

  task automatic step(input logic r, input logic s, input logic v, input logic [15:0] b);
    @(negedge clk);
    rst = r; start = s; bm_valid = v; bm = b;
    @(posedge clk);
    #1;
  endtask

  // Brings every path metric to 5: zero, zero, +3, +2.
  task automatic all_five();
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, mkbm(0,0,0,0,0,0,0,0));
    step(1'b0, 1'b0, 1'b1, mkbm(0,0,0,0,0,0,0,0));
    step(1'b0, 1'b0, 1'b1, mkbm(3,3,3,3,3,3,3,3));
    step(1'b0, 1'b0, 1'b1, mkbm(2,2,2,2,2,2,2,2));
    check("all5_pm", pm_out, pmv(5,5,5,5));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; bm_valid = 1'b0; bm = '0;
    c_pm0 = '0; c_pm1 = '0; c_bm0 = '0; c_bm1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pm", pm_out, pmv(64,64,64,0));
    check("rst_dec", 32'(dec), 32'd0);
    check("rst_dec_valid", 32'(dec_valid), 32'd0);
    check("rst_norm_evt", 32'(norm_evt), 32'd0);

    // First all-zero update.
    step(1'b0, 1'b0, 1'b1, mkbm(0,0,0,0,0,0,0,0));
    check("zero_pm", pm_out, pmv(64,0,64,0));
    check("zero_dec", 32'(dec), 32'd0);
    check("zero_dec_valid", 32'(dec_valid), 32'd1);
    check("zero_norm_evt", 32'(norm_evt), 32'd0);
`ifdef ACS_BEST_STATE_EN
    check("best_state_zero", 32'(best_state), 32'd0);
    check("best_metric_zero", 32'(best_metric), 32'd0);
    step(1'b0, 1'b0, 1'b1, mkbm(3,0,0,0,3,3,0,0));
    check("best_pm", pm_out, pmv(3,0,3,3));
    check("best_state_s2", 32'(best_state), 32'd2);
    check("best_metric_s2", 32'(best_metric), 32'd0);
`endif

    // Select from reset: state 0 sees c0=3, c1=64.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    step(1'b0, 1'b0, 1'b1, mkbm(3,0,0,0,0,0,0,0));
    check("sel_pm", pm_out, pmv(64,0,64,3));
    check("sel_dec", 32'(dec), 32'd0);

    // Equal metrics of 5: bm(0,0)=2, bm(1,0)=1 picks the odd predecessor.
    all_five();
    step(1'b0, 1'b0, 1'b1, mkbm(2,0,1,0,0,0,0,0));
    check("pick1_pm", pm_out, pmv(5,5,5,6));
    check("pick1_dec", 32'(dec), 32'b0001);

    // Idle cycle: metrics and decisions hold, no valid pulse.
    step(1'b0, 1'b0, 1'b0, mkbm(3,3,3,3,3,3,3,3));
    check("hold_pm", pm_out, pmv(5,5,5,6));
    check("hold_dec", 32'(dec), 32'b0001);
    check("hold_dec_valid", 32'(dec_valid), 32'd0);

    // Tie goes to the even predecessor.
    all_five();
    step(1'b0, 1'b0, 1'b1, mkbm(1,0,1,0,0,0,0,0));
    check("tie_pm", pm_out, pmv(5,5,5,6));
    check("tie_dec", 32'(dec), 32'd0);

    // Constant bm=3: min rises by 3 each update until normalisation at 129.
    step(1'b1, 1'b0, 1'b0, 16'h0);
    for (int n = 1; n <= 42; n++) begin
      step(1'b0, 1'b0, 1'b1, mkbm(3,3,3,3,3,3,3,3));
      check($sformatf("ramp%0d_pm0", n), 32'(pm_out[7:0]), 32'(3 * n));
      check($sformatf("ramp%0d_norm", n), 32'(norm_evt), 32'd0);
    end
    step(1'b0, 1'b0, 1'b1, mkbm(3,3,3,3,3,3,3,3));
    check("norm_evt", 32'(norm_evt), 32'd1);
    check("norm_pm", pm_out, pmv(1,1,1,1));
`ifdef ACS_BEST_STATE_EN
    check("norm_best_metric", 32'(best_metric), 32'd1);
    check("norm_best_state", 32'(best_state), 32'd0);
`endif
    step(1'b0, 1'b0, 1'b1, mkbm(3,3,3,3,3,3,3,3));
    check("post_norm_pm", pm_out, pmv(4,4,4,4));
    check("post_norm_evt", 32'(norm_evt), 32'd0);

    // start beats a simultaneous bm_valid.
    step(1'b0, 1'b1, 1'b1, mkbm(3,3,3,3,3,3,3,3));
    check("start_pm", pm_out, pmv(64,64,64,0));
    check("start_dec", 32'(dec), 32'd0);
    check("start_dec_valid", 32'(dec_valid), 32'd0);

    // Mid-stream rst right after a valid update with non-zero decisions.
    all_five();
    step(1'b0, 1'b0, 1'b1, mkbm(2,0,1,0,0,0,0,0));
    step(1'b1, 1'b1, 1'b1, mkbm(3,3,3,3,3,3,3,3));
    check("mrst_pm", pm_out, pmv(64,64,64,0));
    check("mrst_dec", 32'(dec), 32'd0);
    check("mrst_dec_valid", 32'(dec_valid), 32'd0);
    check("mrst_norm_evt", 32'(norm_evt), 32'd0);
    step(1'b0, 1'b0, 1'b0, 16'h0);

    // Saturation corners on a standalone cell.
    c_pm0 = 8'd254; c_bm0 = 2'd3; c_pm1 = 8'd200; c_bm1 = 2'd3; #1;
    check("sat_a_pm", 32'(c_pm_new), 32'd203);
    check("sat_a_dec", 32'(c_dec), 32'd1);
    c_pm0 = 8'd255; c_bm0 = 2'd3; c_pm1 = 8'd255; c_bm1 = 2'd0; #1;
    check("sat_b_pm", 32'(c_pm_new), 32'd255);
    check("sat_b_dec", 32'(c_dec), 32'd0);
    c_pm0 = 8'd253; c_bm0 = 2'd2; c_pm1 = 8'd254; c_bm1 = 2'd3; #1;
    check("sat_c_pm", 32'(c_pm_new), 32'd255);
    check("sat_c_dec", 32'(c_dec), 32'd0);
    c_pm0 = 8'd100; c_bm0 = 2'd1; c_pm1 = 8'd255; c_bm1 = 2'd3; #1;
    check("sat_d_pm", 32'(c_pm_new), 32'd101);
    check("sat_d_dec", 32'(c_dec), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
